// File: rtl/light_phase_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : light_phase_sequencer_pkg
// Purpose  : Shared types and constants for the two-direction traffic light
//            phase sequencer: phase encoding, mode codes, LED encodings,
//            default durations, counter width, maximum cycle sum, and a helper
//            that maps a phase to its active duration.
// Ports    : (package - no ports)
// Revision : 1.0 - initial release
// ============================================================================
package light_phase_sequencer_pkg;

    localparam int unsigned c_CNT_W   = 7;
    localparam int unsigned c_MAX_SUM = 99;

    localparam logic [c_CNT_W-1:0] c_DEF_GREEN  = 7'd25;
    localparam logic [c_CNT_W-1:0] c_DEF_YELLOW = 7'd3;

    // S0: dir1 green, S1: dir1 yellow, S2: dir2 green, S3: dir2 yellow
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } phase_e;

    localparam logic [1:0] c_MODE_AUTO   = 2'd0;
    localparam logic [1:0] c_MODE_MANUAL = 2'd1;
    localparam logic [1:0] c_MODE_CONFIG = 2'd2;   // code 3 behaves as config

    // {R,Y,G}
    localparam logic [2:0] c_LED_R = 3'b100;
    localparam logic [2:0] c_LED_Y = 3'b010;
    localparam logic [2:0] c_LED_G = 3'b001;

    // Green phases (S0/S2) run for the green time, yellow phases for yellow.
    function automatic logic [c_CNT_W-1:0] phase_duration(
        input phase_e             ph,
        input logic [c_CNT_W-1:0] green,
        input logic [c_CNT_W-1:0] yellow
    );
        return ((ph == S0) || (ph == S2)) ? green : yellow;
    endfunction

endpackage : light_phase_sequencer_pkg
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : phase_timer
// Purpose  : Loadable down counter holding the remaining seconds of the
//            current phase. Load has priority over decrement; the counter
//            never wraps below zero.
// Ports    : clk        - clock, rising edge
//            reset      - synchronous active-high reset (loads RESET_VAL)
//            load_i     - load load_val_i this cycle
//            load_val_i - value to load
//            dec_i      - decrement by one
//            value_o    - current count
//            at_one_o   - count equals one (last second of the phase)
// Revision : 1.0 - initial release
// ============================================================================
module phase_timer
    import light_phase_sequencer_pkg::*;
#(
    parameter logic [c_CNT_W-1:0] RESET_VAL = c_DEF_GREEN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [c_CNT_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic [c_CNT_W-1:0] value_o,
    output logic               at_one_o
);

    logic [c_CNT_W-1:0] value_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= RESET_VAL;
        end else if (load_i) begin
            value_q <= load_val_i;
        end else if (dec_i && (value_q != '0)) begin
            value_q <= value_q - 1'b1;
        end
    end

    assign value_o  = value_q;
    assign at_one_o = (value_q == 7'd1);

endmodule : phase_timer
`default_nettype wire

// File: rtl/light_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : light_phase_sequencer
// Purpose  : Two-direction traffic light phase sequencer with auto, manual
//            and config modes, shadowed duration configuration and per
//            direction remaining-time outputs.
// Ports    : clk                - clock, rising edge
//            reset              - synchronous active-high reset
//            tick               - 1 Hz one-cycle enable
//            mode               - 0 auto, 1 manual, 2/3 config
//            step               - manual phase advance pulse
//            cfg_load           - write cfg_green/cfg_yellow into shadow
//            cfg_green/yellow   - requested durations (seconds)
//            cfg_err            - one-cycle pulse on rejected cfg_load
//            led1, led2         - {R,Y,G} per direction
//            count1, count2     - remaining seconds per direction
//            phase              - current phase S0..S3
// Revision : 1.0 - initial release
// ============================================================================
module light_phase_sequencer
    import light_phase_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [1:0]         mode,
    input  logic               step,
    input  logic               cfg_load,
    input  logic [c_CNT_W-1:0] cfg_green,
    input  logic [c_CNT_W-1:0] cfg_yellow,
    output logic               cfg_err,
    output logic [2:0]         led1,
    output logic [2:0]         led2,
    output logic [c_CNT_W-1:0] count1,
    output logic [c_CNT_W-1:0] count2,
    output logic [1:0]         phase
);

    phase_e             phase_q, phase_d;
    logic [c_CNT_W-1:0] green_act_q, green_act_d;
    logic [c_CNT_W-1:0] yellow_act_q, yellow_act_d;
    logic [c_CNT_W-1:0] green_sh_q, green_sh_d;
    logic [c_CNT_W-1:0] yellow_sh_q, yellow_sh_d;
    logic               cfg_err_q;
    logic               prev_cfg_q;
    logic               prev_manual_q;

    logic               w_is_cfg, w_is_manual, w_is_auto, w_cfg_exit;
    logic [c_CNT_W:0]   w_cfg_sum;
    logic               w_cfg_ok;
    phase_e             w_next_phase;
    logic               w_advance;
    logic               w_tmr_load, w_tmr_dec, w_tmr_at_one;
    logic [c_CNT_W-1:0] w_tmr_load_val, w_cnt, w_red_sum;

    assign w_is_cfg     = (mode >= c_MODE_CONFIG);
    assign w_is_manual  = (mode == c_MODE_MANUAL);
    assign w_is_auto    = (mode == c_MODE_AUTO);
    assign w_cfg_exit   = prev_cfg_q && !w_is_cfg;
    assign w_next_phase = phase_e'(phase_q + 2'd1);

    // One extra bit so out-of-range requests cannot wrap into the valid range.
    assign w_cfg_sum = {1'b0, cfg_green} + {1'b0, cfg_yellow};
    assign w_cfg_ok  = (cfg_green != '0) && (cfg_yellow != '0) &&
                       (w_cfg_sum <= (c_CNT_W+1)'(c_MAX_SUM));

    phase_timer #(
        .RESET_VAL (c_DEF_GREEN)
    ) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_load_val),
        .dec_i      (w_tmr_dec),
        .value_o    (w_cnt),
        .at_one_o   (w_tmr_at_one)
    );

    always_comb begin
        phase_d        = phase_q;
        green_act_d    = green_act_q;
        yellow_act_d   = yellow_act_q;
        green_sh_d     = green_sh_q;
        yellow_sh_d    = yellow_sh_q;
        w_tmr_load     = 1'b0;
        w_tmr_dec      = 1'b0;
        w_tmr_load_val = w_cnt;
        w_advance      = 1'b0;

        if (cfg_load && w_cfg_ok) begin
            green_sh_d  = cfg_green;
            yellow_sh_d = cfg_yellow;
        end

        // Mode transitions are detected against last cycle's mode and take
        // precedence over step/tick in the same cycle.
        if (w_cfg_exit) begin
            phase_d        = S0;
            green_act_d    = green_sh_d;
            yellow_act_d   = yellow_sh_d;
            w_tmr_load     = 1'b1;
            w_tmr_load_val = green_sh_d;
        end else if (w_is_cfg) begin
            // frozen: phase and count held
        end else if (w_is_auto && prev_manual_q) begin
            w_tmr_load     = 1'b1;
            w_tmr_load_val = phase_duration(phase_q, green_act_q, yellow_act_q);
        end else if (w_is_manual && prev_manual_q) begin
            w_advance = step;
        end else if (w_is_auto) begin
            if (tick) begin
                if (w_tmr_at_one) begin
                    w_advance = 1'b1;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
        end

        if (w_advance) begin
            phase_d    = w_next_phase;
            w_tmr_load = 1'b1;
            // Entering S0 is the only point where the shadow becomes active;
            // a load accepted on this very edge is already included.
            if (w_next_phase == S0) begin
                green_act_d    = green_sh_d;
                yellow_act_d   = yellow_sh_d;
                w_tmr_load_val = green_sh_d;
            end else begin
                w_tmr_load_val = phase_duration(w_next_phase, green_act_q, yellow_act_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q       <= S0;
            green_act_q   <= c_DEF_GREEN;
            yellow_act_q  <= c_DEF_YELLOW;
            green_sh_q    <= c_DEF_GREEN;
            yellow_sh_q   <= c_DEF_YELLOW;
            cfg_err_q     <= 1'b0;
            prev_cfg_q    <= 1'b0;
            prev_manual_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            green_act_q   <= green_act_d;
            yellow_act_q  <= yellow_act_d;
            green_sh_q    <= green_sh_d;
            yellow_sh_q   <= yellow_sh_d;
            cfg_err_q     <= cfg_load && !w_cfg_ok;
            prev_cfg_q    <= w_is_cfg;
            prev_manual_q <= w_is_manual;
        end
    end

    // Red side waits for the other direction's green plus its yellow; the
    // accepted configuration guarantees this fits in 7 bits.
    assign w_red_sum = w_cnt + yellow_act_q;

    always_comb begin
        led1   = c_LED_R;
        led2   = c_LED_R;
        count1 = '0;
        count2 = '0;
        if (w_is_cfg) begin
            led1 = c_LED_Y;
            led2 = c_LED_Y;
        end else begin
            case (phase_q)
                S0: begin
                    led1 = c_LED_G;
                    if (w_is_auto) begin
                        count1 = w_cnt;
                        count2 = w_red_sum;
                    end
                end
                S1: begin
                    led1 = c_LED_Y;
                    if (w_is_auto) begin
                        count1 = w_cnt;
                        count2 = w_cnt;
                    end
                end
                S2: begin
                    led2 = c_LED_G;
                    if (w_is_auto) begin
                        count1 = w_red_sum;
                        count2 = w_cnt;
                    end
                end
                S3: begin
                    led2 = c_LED_Y;
                    if (w_is_auto) begin
                        count1 = w_cnt;
                        count2 = w_cnt;
                    end
                end
                default: begin
                    led1 = c_LED_R;
                    led2 = c_LED_R;
                end
            endcase
        end
    end

    assign cfg_err = cfg_err_q;
    assign phase   = phase_q;

endmodule : light_phase_sequencer
`default_nettype wire
